// File: rtl/wr_fifo_width_converter.sv
// -----------------------------------------------------------------------------
// wr_fifo_width_converter
//
// Pops IN_WIDTH words from a first-word-fall-through write FIFO and hands them
// to the flash controller one OUT_WIDTH slice at a time. Slice order is
// selectable (most- or least-significant slice first). With PREFETCH=1 a
// second word register is kept filled from the FIFO independently of the
// controller, so word boundaries cost no empty cycle. A flush discards any
// partially consumed word together with the prefetched one.
//
// Parameters
//   IN_WIDTH   FIFO word width, an integer multiple of OUT_WIDTH
//   OUT_WIDTH  slice width presented to the controller
//   MSB_FIRST  1: slice 0 is the top OUT_WIDTH bits; 0: slice 0 is the bottom
//   PREFETCH   1: active + prefetch word registers; 0: active register only
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wr_fifo_data    FIFO head, valid whenever !i_wr_fifo_empty
//   i_wr_fifo_empty   FIFO empty flag
//   o_wr_fifo_re      pop strobe; the head is captured on the same edge
//   o_ctrl_data       current slice of the active word
//   i_ctrl_re         controller takes o_ctrl_data this cycle
//   o_ctrl_empty      no slice available
//   i_flush           drop active/prefetch words, restart at slice 0
//   o_word_done       pulse when the last slice of a word is consumed
//   o_slice_idx       index of the slice currently presented
// -----------------------------------------------------------------------------
module wr_fifo_width_converter #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 8,
    parameter int MSB_FIRST = 1,
    parameter int PREFETCH  = 1,
    // Derived; not intended to be overridden.
    parameter int N         = IN_WIDTH / OUT_WIDTH,
    parameter int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [IN_WIDTH-1:0]  i_wr_fifo_data,
    input  logic                 i_wr_fifo_empty,
    output logic                 o_wr_fifo_re,
    output logic [OUT_WIDTH-1:0] o_ctrl_data,
    input  logic                 i_ctrl_re,
    output logic                 o_ctrl_empty,
    input  logic                 i_flush,
    output logic                 o_word_done,
    output logic [IDX_W-1:0]     o_slice_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Active word being sliced, and the word queued behind it.
    logic                act_valid_q, act_valid_d;
    logic [IN_WIDTH-1:0] act_data_q,  act_data_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic                pf_valid_q,  pf_valid_d;
    logic [IN_WIDTH-1:0] pf_data_q,   pf_data_d;

    logic consume;
    logic last;
    logic pop;
    logic act_free;

    // A flush or reset cycle never consumes, so no word_done and no idx step.
    assign consume = i_ctrl_re & act_valid_q & ~i_flush & ~i_rst;
    assign last    = consume & (idx_q == LAST_IDX);

    // With prefetch the pop only depends on register occupancy, so the FIFO
    // read path is decoupled from the controller's read strobe.
    always_comb begin
        pop = 1'b0;
        if (!i_rst && !i_wr_fifo_empty && !i_flush) begin
            if (PREFETCH != 0) begin
                pop = ~act_valid_q | ~pf_valid_q;
            end else begin
                pop = ~act_valid_q | last;
            end
        end
    end

    // The active register is free after this cycle if it holds nothing, or
    // its last slice leaves now with nothing waiting in the prefetch slot.
    assign act_free = ~act_valid_q | (last & ~pf_valid_q);

    always_comb begin
        act_valid_d = act_valid_q;
        act_data_d  = act_data_q;
        idx_d       = idx_q;
        pf_valid_d  = pf_valid_q;
        pf_data_d   = pf_data_q;

        if (i_flush) begin
            act_valid_d = 1'b0;
            pf_valid_d  = 1'b0;
            idx_d       = '0;
        end else begin
            if (last) begin
                idx_d = '0;
            end else if (consume) begin
                idx_d = idx_q + IDX_W'(1);
            end

            // Word boundary: promote the prefetched word, or go empty.
            if (last) begin
                if (pf_valid_q) begin
                    act_data_d = pf_data_q;
                    pf_valid_d = 1'b0;
                end else begin
                    act_valid_d = 1'b0;
                end
            end

            // A popped word lands in the active register when that is free,
            // otherwise it refills the prefetch slot.
            if (pop) begin
                if (act_free) begin
                    act_data_d  = i_wr_fifo_data;
                    act_valid_d = 1'b1;
                end else if (PREFETCH != 0) begin
                    pf_data_d  = i_wr_fifo_data;
                    pf_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            act_valid_q <= 1'b0;
            act_data_q  <= '0;
            idx_q       <= '0;
            pf_valid_q  <= 1'b0;
            pf_data_q   <= '0;
        end else begin
            act_valid_q <= act_valid_d;
            act_data_q  <= act_data_d;
            idx_q       <= idx_d;
            pf_valid_q  <= pf_valid_d;
            pf_data_q   <= pf_data_d;
        end
    end

    // Slice select: slice s sits at word position s (LSB first) or N-1-s
    // (MSB first), counted in OUT_WIDTH units from bit 0.
    always_comb begin
        o_ctrl_data = '0;
        for (int s = 0; s < N; s++) begin
            if (idx_q == IDX_W'(s)) begin
                o_ctrl_data = act_data_q[((MSB_FIRST != 0) ? (N - 1 - s) : s) * OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign o_wr_fifo_re = pop;
    assign o_ctrl_empty = ~act_valid_q;
    assign o_word_done  = last;
    assign o_slice_idx  = idx_q;

endmodule

// File: tb/tb_wr_fifo_width_converter.sv
module tb_wr_fifo_width_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: 128 -> 8, MSB first, prefetch
    logic [127:0] a_fd;
    logic         a_fe, a_re, a_cre, a_ce, a_fl, a_wd;
    logic [7:0]   a_cd;
    logic [3:0]   a_idx;

    // DUT B: 128 -> 32, LSB first, no prefetch
    logic [127:0] b_fd;
    logic         b_fe, b_re, b_cre, b_ce, b_fl, b_wd;
    logic [31:0]  b_cd;
    logic [1:0]   b_idx;

    wr_fifo_width_converter #(.IN_WIDTH(128), .OUT_WIDTH(8), .MSB_FIRST(1), .PREFETCH(1)) u_a (
        .i_clk(clk), .i_rst(rst),
        .i_wr_fifo_data(a_fd), .i_wr_fifo_empty(a_fe), .o_wr_fifo_re(a_re),
        .o_ctrl_data(a_cd), .i_ctrl_re(a_cre), .o_ctrl_empty(a_ce),
        .i_flush(a_fl), .o_word_done(a_wd), .o_slice_idx(a_idx)
    );

    wr_fifo_width_converter #(.IN_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(0), .PREFETCH(0)) u_b (
        .i_clk(clk), .i_rst(rst),
        .i_wr_fifo_data(b_fd), .i_wr_fifo_empty(b_fe), .o_wr_fifo_re(b_re),
        .o_ctrl_data(b_cd), .i_ctrl_re(b_cre), .o_ctrl_empty(b_ce),
        .i_flush(b_fl), .o_word_done(b_wd), .o_slice_idx(b_idx)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic [127:0] a_fifo[$];
    logic [127:0] b_fifo[$];
    exp_t         a_exp[$];
    exp_t         b_exp[$];

    int errs   = 0;
    int checks = 0;
    int a_pops = 0, b_pops = 0;
    int a_empty_cnt = 0, b_empty_cnt = 0;
    bit a_rand = 0, b_rand = 0;

    localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        a_fe = (a_fifo.size() == 0);
        a_fd = a_fe ? 128'h0 : a_fifo[0];
        b_fe = (b_fifo.size() == 0);
        b_fd = b_fe ? 128'h0 : b_fifo[0];
    endtask

    // A: slice s is byte (15-s) counted from the bottom.
    task automatic push_a(input logic [127:0] w);
        exp_t e;
        logic [127:0] sh;
        a_fifo.push_back(w);
        for (int s = 0; s < 16; s++) begin
            sh     = w >> (8 * (15 - s));
            e.idx  = 4'(s);
            e.last = (s == 15);
            e.data = {24'h0, sh[7:0]};
            a_exp.push_back(e);
        end
        refresh();
    endtask

    // B: slice s is 32-bit lane s counted from the bottom.
    task automatic push_b(input logic [127:0] w);
        exp_t e;
        logic [127:0] sh;
        b_fifo.push_back(w);
        for (int s = 0; s < 4; s++) begin
            sh     = w >> (32 * s);
            e.idx  = 4'(s);
            e.last = (s == 3);
            e.data = sh[31:0];
            b_exp.push_back(e);
        end
        refresh();
    endtask

    // One clock: observe at the falling edge, update the FIFO models and
    // random strobes just after the rising edge.
    task automatic cyc();
        exp_t e;
        logic a_pop, b_pop;
        logic [127:0] dummy;
        @(negedge clk);
        a_pop = a_re;
        b_pop = b_re;
        if (a_re) begin
            check("a_pop_nonempty", 128'(a_fifo.size() != 0), 128'h1);
            a_pops++;
        end
        if (b_re) begin
            check("b_pop_nonempty", 128'(b_fifo.size() != 0), 128'h1);
            b_pops++;
        end
        if (!rst && a_ce) a_empty_cnt++;
        if (!rst && b_ce) b_empty_cnt++;

        if (!rst && a_cre && !a_ce && !a_fl) begin
            if (a_exp.size() == 0) begin
                check("a_exp_underflow", 128'h1, 128'h0);
            end else begin
                e = a_exp.pop_front();
                check("a_data", 128'(a_cd), 128'(e.data));
                check("a_idx", 128'(a_idx), 128'(e.idx));
                check("a_done", 128'(a_wd), 128'(e.last));
            end
        end else begin
            check("a_done_idle", 128'(a_wd), 128'h0);
        end

        if (!rst && b_cre && !b_ce && !b_fl) begin
            if (b_exp.size() == 0) begin
                check("b_exp_underflow", 128'h1, 128'h0);
            end else begin
                e = b_exp.pop_front();
                check("b_data", 128'(b_cd), 128'(e.data));
                check("b_idx", 128'(b_idx), 128'(e.idx));
                check("b_done", 128'(b_wd), 128'(e.last));
            end
        end else begin
            check("b_done_idle", 128'(b_wd), 128'h0);
        end

        @(posedge clk);
        #1;
        if (a_pop && a_fifo.size() != 0) dummy = a_fifo.pop_front();
        if (b_pop && b_fifo.size() != 0) dummy = b_fifo.pop_front();
        if (a_rand) a_cre = 1'($urandom_range(0, 1));
        if (b_rand) b_cre = 1'($urandom_range(0, 1));
        refresh();
    endtask

    task automatic drain(input string tag, input int maxc, output int n);
        n = 0;
        while ((a_exp.size() != 0 || b_exp.size() != 0) && n < maxc) begin
            cyc();
            n++;
        end
        check({tag, "_left"}, 128'(a_exp.size() + b_exp.size()), 128'h0);
    endtask

    int n;

    initial begin
        rst   = 1'b1;
        a_cre = 1'b0; a_fl = 1'b0;
        b_cre = 1'b0; b_fl = 1'b0;
        refresh();
        repeat (3) cyc();

        // Reset state, with a word already waiting in the FIFO.
        push_a(W0);
        #1;
        check("rst_a_empty", 128'(a_ce), 128'h1);
        check("rst_a_data", 128'(a_cd), 128'h0);
        check("rst_a_idx", 128'(a_idx), 128'h0);
        check("rst_a_done", 128'(a_wd), 128'h0);
        check("rst_a_re", 128'(a_re), 128'h0);
        check("rst_b_empty", 128'(b_ce), 128'h1);
        check("rst_b_data", 128'(b_cd), 128'h0);
        cyc();

        // Test 1: single word, MSB first, read strobe held high.
        rst = 1'b0;
        #1;
        check("t1_pop_now", 128'(a_re), 128'h1);
        check("t1_still_empty", 128'(a_ce), 128'h1);
        a_cre = 1'b1;
        cyc();
        check("t1_valid_next", 128'(a_ce), 128'h0);
        drain("t1", 40, n);
        check("t1_cycles", 128'(n), 128'd16);
        check("t1_empty_after", 128'(a_ce), 128'h1);

        // Test 2: two words back-to-back through the prefetch slot.
        a_pops = 0;
        a_empty_cnt = 0;
        push_a(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
        push_a(128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF);
        drain("t2", 80, n);
        check("t2_cycles", 128'(n), 128'd33);
        check("t2_pops", 128'(a_pops), 128'd2);
        check("t2_empty_cycles", 128'(a_empty_cnt), 128'd1);

        // Test 4: read strobe while empty is ignored.
        a_pops = 0;
        repeat (3) begin
            check("t4_idx", 128'(a_idx), 128'h0);
            check("t4_re", 128'(a_re), 128'h0);
            cyc();
        end
        check("t4_pops", 128'(a_pops), 128'h0);
        check("t4_empty", 128'(a_ce), 128'h1);

        // Test 5: flush after 5 slices with the prefetch slot occupied.
        push_a(128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF);
        push_a(128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF);
        repeat (6) cyc();
        check("t5_idx5", 128'(a_idx), 128'd5);
        check("t5_fifo_drained", 128'(a_fifo.size()), 128'h0);
        a_exp.delete();
        push_a(128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF);
        a_fl = 1'b1;
        #1;
        check("t5_flush_nopop", 128'(a_re), 128'h0);
        cyc();
        a_fl = 1'b0;
        #1;
        check("t5_empty", 128'(a_ce), 128'h1);
        check("t5_idx0", 128'(a_idx), 128'h0);
        drain("t5", 40, n);
        check("t5_cycles", 128'(n), 128'd17);

        // Test 6: reset in the middle of a word.
        push_a(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        repeat (8) cyc();
        check("t6_idx7", 128'(a_idx), 128'd7);
        a_exp.delete();
        push_a(128'h13579BDF_2468ACE0_FEDCBA98_76543210);
        rst = 1'b1;
        #1;
        check("t6_rst_nopop", 128'(a_re), 128'h0);
        cyc();
        rst = 1'b0;
        #1;
        check("t6_empty", 128'(a_ce), 128'h1);
        check("t6_data0", 128'(a_cd), 128'h0);
        check("t6_idx0", 128'(a_idx), 128'h0);
        drain("t6", 40, n);
        check("t6_cycles", 128'(n), 128'd17);

        // Test 3: 32-bit LSB-first slices, no prefetch.
        a_cre = 1'b0;
        b_cre = 1'b1;
        push_b(W0);
        drain("t3", 20, n);
        check("t3_cycles", 128'(n), 128'd5);
        b_pops = 0;
        b_empty_cnt = 0;
        push_b(128'h11111111_22222222_33333333_44444444);
        push_b(128'h55555555_66666666_77777777_88888888);
        drain("t3b", 30, n);
        check("t3b_cycles", 128'(n), 128'd9);
        check("t3b_pops", 128'(b_pops), 128'd2);
        check("t3b_empty_cycles", 128'(b_empty_cnt), 128'd1);

        // Irregular read strobe on both converters.
        a_rand = 1'b1;
        b_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_a({$urandom, $urandom, $urandom, $urandom});
            push_b({$urandom, $urandom, $urandom, $urandom});
        end
        drain("rnd", 1000, n);
        a_rand = 1'b0;
        b_rand = 1'b0;
        a_cre = 1'b0;
        b_cre = 1'b0;
        cyc();
        check("rnd_a_empty", 128'(a_ce), 128'h1);
        check("rnd_b_empty", 128'(b_ce), 128'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
